// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single memory_controller port between the
// instruction-fetch requester and the data (load/store) requester.
//
// Handshake: a requester holds req (and its address/data) high; gnt rises
// combinationally in the same cycle the transfer is issued; exactly one cycle
// later the owner sees valid=1 with rdata/abort. The requester may drop or
// change req after its gnt cycle; a req still high after gnt is a new request.
//
// Transfers are issued at most one per cycle and answered in issue order.
// Addresses at or above MEM_WORDS are answered locally with an abort and
// never reach memory (m_trans=00).
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_WORDS    = 8192
) (
    input  logic        clk,
    input  logic        n_reset,
    // fetch requester
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_rdata,
    output logic        f_abort,
    // data requester
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_write,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_abort,
    // memory_controller port
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    output logic        m_size,
    output logic [1:0]  m_prot,
    output logic [1:0]  m_trans,
    input  logic [31:0] m_rdata,
    input  logic        m_abort,
    // debug: current arbiter state (0 = IDLE, 1 = LOCKED)
    output logic        dbg_state
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [31:0] MEM_TOP    = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;

    // last memory issue: valid only if it happened in the previous cycle
    logic        last_vld_q, last_vld_d;
    logic        last_owner_q, last_owner_d;   // 1 = data, 0 = fetch
    logic [31:0] last_addr_q, last_addr_d;

    // response pending for the next cycle
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_owner_q, rsp_owner_d;     // 1 = data, 0 = fetch
    logic        rsp_write_q, rsp_write_d;
    logic        rsp_lab_q, rsp_lab_d;         // local (out-of-range) abort

    logic        gnt_any;
    logic [31:0] gnt_addr;
    logic        in_range;
    logic        issue;
    logic        seq;
    logic [31:0] rsp_rdata;
    logic        rsp_abort;

    // Grant selection: LOCKED serves only data; IDLE favours data unless fetch is starved.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (n_reset) begin
            if (state_q == ST_LOCKED) begin
                d_gnt = d_req;
            end else if (f_req && (starve_cnt_q == STARVE_MAX)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Drive the memory port from the granted requester and classify the transfer.
    always_comb begin
        gnt_any  = f_gnt | d_gnt;
        gnt_addr = d_gnt ? d_addr : f_addr;
        in_range = gnt_addr < MEM_TOP;
        issue    = gnt_any & in_range;
        seq      = last_vld_q && (last_owner_q == d_gnt) &&
                   (gnt_addr == last_addr_q + 32'd1);

        m_addr   = gnt_any ? gnt_addr : 32'd0;
        m_wdata  = d_gnt ? d_wdata : 32'd0;
        m_write  = d_gnt & d_write;
        m_size   = 1'b1;
        m_prot   = {1'b0, d_gnt};
        m_trans  = issue ? {1'b1, seq} : 2'b00;
    end

    // Next-state: lock tracking, fetch starvation counter, issue history, response tag.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        last_vld_d   = issue;
        last_owner_d = d_gnt;
        last_addr_d  = issue ? gnt_addr : last_addr_q;
        rsp_vld_d    = gnt_any;
        rsp_owner_d  = d_gnt;
        rsp_write_d  = d_gnt & d_write;
        rsp_lab_d    = gnt_any & ~in_range;

        case (state_q)
            ST_IDLE: begin
                if (d_gnt && d_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (!d_req || (d_gnt && !d_lock)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (f_gnt) begin
            starve_cnt_d = 8'd0;
        end else if (f_req && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // State registers; reset discards any pending response and issue history.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 8'd0;
            last_vld_q   <= 1'b0;
            last_owner_q <= 1'b0;
            last_addr_q  <= 32'd0;
            rsp_vld_q    <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_lab_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            last_vld_q   <= last_vld_d;
            last_owner_q <= last_owner_d;
            last_addr_q  <= last_addr_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_write_q  <= rsp_write_d;
            rsp_lab_q    <= rsp_lab_d;
        end
    end

    // Steer the one-cycle-later memory response to its owner; stores and local aborts return 0.
    always_comb begin
        rsp_rdata = (rsp_write_q | rsp_lab_q) ? 32'd0 : m_rdata;
        rsp_abort = m_abort | rsp_lab_q;

        f_valid   = rsp_vld_q & ~rsp_owner_q;
        d_valid   = rsp_vld_q & rsp_owner_q;
        f_rdata   = f_valid ? rsp_rdata : 32'd0;
        d_rdata   = d_valid ? rsp_rdata : 32'd0;
        f_abort   = f_valid & rsp_abort;
        d_abort   = d_valid & rsp_abort;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a behavioural memory sits on the m_* port,
// expected responses are queued when a grant is expected and popped one cycle later.
module tb_memory_arbiter;

  logic        clk;
  logic        n_reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_valid, f_abort;
  logic [31:0] f_rdata;
  logic        d_req, d_write, d_lock;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_valid, d_abort;
  logic [31:0] d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_write, m_size, m_abort;
  logic [1:0]  m_prot, m_trans;
  logic        dbg_state;

  memory_arbiter #(.STARVE_LIMIT(4), .MEM_WORDS(8192)) dut (
    .clk(clk), .n_reset(n_reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_rdata(f_rdata), .f_abort(f_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_abort(d_abort),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_size(m_size),
    .m_prot(m_prot), .m_trans(m_trans), .m_rdata(m_rdata), .m_abort(m_abort),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory device ----------------
  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] mem [0:8191];
  logic [8191:0] mem_wr;
  logic        mem_clr;
  logic [12:0] mem_idx;
  assign mem_idx = m_addr[12:0];

  always @(posedge clk) begin
    if (mem_clr) mem_wr <= '0;
    if (m_trans[1]) begin
      if (m_write) begin
        mem[mem_idx]    <= m_wdata;
        mem_wr[mem_idx] <= 1'b1;
        m_rdata         <= 32'hA5A5_A5A5;
      end else begin
        m_rdata <= mem_wr[mem_idx] ? mem[mem_idx] : init_pat(m_addr);
      end
      m_abort <= (m_addr == 32'd100);
    end else begin
      m_rdata <= 32'hBADC_0FFE;
      m_abort <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry: {owner_is_data, abort, rdata}
  logic [33:0] exp_q[$];
  logic [31:0] ref_mem [0:8191];
  logic [8191:0] ref_wr;
  int n_vec = 0;
  int n_err = 0;

  int          d_tab[10]  = '{30, 31, 32, 33, 34, 34, 35, 36, 37, 38};
  logic [1:0]  tr_tab[10] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10,
                              2'b10, 2'b11, 2'b11, 2'b11, 2'b10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: inputs already driven; check previous response and current grant.
  task automatic step(input logic efg, input logic edg, input logic [1:0] etrans,
                      input logic [1:0] eprot);
    logic [33:0] e;
    logic        has, oor, wr, ab;
    logic [31:0] a, rd;
    @(negedge clk);
    has = 1'b0;
    e   = '0;
    if (exp_q.size() > 0) begin
      has = 1'b1;
      e   = exp_q.pop_front();
    end
    chk("f_valid", f_valid, has & ~e[33]);
    chk("d_valid", d_valid, has & e[33]);
    chk("f_rdata", f_rdata, (has & ~e[33]) ? e[31:0] : 32'd0);
    chk("d_rdata", d_rdata, (has & e[33]) ? e[31:0] : 32'd0);
    if (has & ~e[33]) chk("f_abort", f_abort, e[32]);
    if (has & e[33])  chk("d_abort", d_abort, e[32]);
    chk("f_gnt", f_gnt, efg);
    chk("d_gnt", d_gnt, edg);
    chk("m_trans", m_trans, etrans);
    chk("m_size", m_size, 1);
    a = efg ? f_addr : d_addr;
    if (etrans != 2'b00) begin
      chk("m_prot", m_prot, eprot);
      chk("m_addr", m_addr, a);
      chk("m_write", m_write, edg & d_write);
      chk("m_wdata", m_wdata, (edg & d_write) ? d_wdata : 32'd0);
    end else if (!efg && !edg) begin
      chk("m_addr_idle", m_addr, 0);
      chk("m_wdata_idle", m_wdata, 0);
      chk("m_write_idle", m_write, 0);
      chk("m_prot_idle", m_prot, 0);
    end
    if (efg | edg) begin
      oor = (a >= 32'd8192);
      wr  = edg & d_write;
      ab  = oor | (a == 32'd100);
      rd  = (oor | wr) ? 32'd0 :
            (ref_wr[a[12:0]] ? ref_mem[a[12:0]] : init_pat(a));
      if (wr && !oor) begin
        ref_mem[a[12:0]] = d_wdata;
        ref_wr[a[12:0]]  = 1'b1;
      end
      exp_q.push_back({edg, ab, rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_write = 1'b0; d_lock = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    ref_wr  = '0;
    mem_clr = 1'b1;
    // reset with both requesters active: nothing may be granted or driven
    n_reset = 1'b0;
    f_req = 1'b1; f_addr = 32'd5;
    d_req = 1'b1; d_addr = 32'd6; d_wdata = 32'hFFFF_FFFF; d_write = 1'b1; d_lock = 1'b0;
    #12;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_trans", m_trans, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_prot", m_prot, 0);
    chk("rst_m_size", m_size, 1);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    mem_clr = 1'b0;
    n_reset = 1'b1;
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // preload mem[5] through the data port, then fetch it back
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'd5; d_wdata = 32'hDEAD_BEEF;
    step(0, 1, 2'b10, 2'b01);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);
    f_req = 1'b1; f_addr = 32'd5;
    step(1, 0, 2'b10, 2'b00);
    f_addr = 32'd6;
    step(1, 0, 2'b11, 2'b00);
    f_req = 1'b0; d_req = 1'b1; d_addr = 32'd7;
    step(0, 1, 2'b10, 2'b01);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);
    f_req = 1'b1; f_addr = 32'd5;
    step(1, 0, 2'b10, 2'b00);
    f_req = 1'b0; d_req = 1'b1; d_addr = 32'd6;
    step(0, 1, 2'b10, 2'b01);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // starvation bound: both held for 10 cycles
    f_req = 1'b1; f_addr = 32'd20; d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_addr = d_tab[i];
      if (i == 4 || i == 9) step(1, 0, tr_tab[i], 2'b00);
      else                  step(0, 1, tr_tab[i], 2'b01);
    end
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // store then load at address 10
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'd10; d_wdata = 32'h1234_5678;
    step(0, 1, 2'b10, 2'b01);
    d_write = 1'b0; d_wdata = 32'h0;
    step(0, 1, 2'b10, 2'b01);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // locked data burst keeps fetch out even once starved
    f_req = 1'b1; f_addr = 32'd40; d_req = 1'b1; d_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_addr = 32'd50 + 32'(i);
      step(0, 1, (i == 0) ? 2'b10 : 2'b11, 2'b01);
      chk("locked_state", dbg_state, 1);
    end
    d_lock = 1'b0; d_addr = 32'd58;
    step(0, 1, 2'b11, 2'b01);
    chk("unlock_state", dbg_state, 0);
    d_addr = 32'd59;
    step(1, 0, 2'b10, 2'b00);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // out-of-range accesses: granted, no memory transfer, local abort
    d_req = 1'b1; d_addr = 32'd8192;
    step(0, 1, 2'b00, 2'b01);
    idle_inputs();
    f_req = 1'b1; f_addr = 32'hFFFF_FFFF;
    step(1, 0, 2'b00, 2'b00);
    // memory-signalled abort at address 100
    f_addr = 32'd100;
    step(1, 0, 2'b10, 2'b00);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);

    // reset during a response cycle: valid drops at once, no late response
    d_req = 1'b1; d_addr = 32'd5;
    step(0, 1, 2'b10, 2'b01);
    idle_inputs();
    n_reset = 1'b0;
    #1;
    chk("rstrsp_d_valid", d_valid, 0);
    chk("rstrsp_d_rdata", d_rdata, 0);
    chk("rstrsp_f_valid", f_valid, 0);
    chk("rstrsp_d_abort", d_abort, 0);
    exp_q.delete();
    @(posedge clk); #1;
    n_reset = 1'b1;
    step(0, 0, 2'b00, 2'b00);
    f_req = 1'b1; f_addr = 32'd5;
    step(1, 0, 2'b10, 2'b00);
    idle_inputs();
    step(0, 0, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
